demo_txn_sequencer: RTL and testbench

Synthesizable, parametrised stimulus engine that replaces hand-timed start/mode pokes on the demo bus masters. It sits beside dual_bus_top-style systems and drives N_CH independent demo ports. Each demo port has an active-low edge-triggered demo_start, a level demo_mode (1=write, 0=read) and a demo_ready completion flag. The sequencer issues a programmed number of write/read transactions round-robin over enabled channels, waits for each completion with a timeout, and reports counts and errors.

---
 rtl/demo_txn_sequencer_pkg.sv | 35 +++
 rtl/demo_txn_sequencer_if.sv | 21 ++
 rtl/demo_txn_sequencer_rr_next_sel.sv | 22 ++
 rtl/demo_txn_sequencer.sv | 170 +++++++++++++++++
 tb/tb_demo_txn_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/demo_txn_sequencer_pkg.sv
// Shared types for the demo transaction sequencer:
// FSM states, mode_sel encodings and the per-transaction mode helper.
package demo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT,
        NEXT,
        DONE
    } state_e;

    localparam logic [1:0] MODE_ALT_W = 2'd0;
    localparam logic [1:0] MODE_ALL_W = 2'd1;
    localparam logic [1:0] MODE_ALL_R = 2'd2;
    localparam logic [1:0] MODE_ALT_R = 2'd3;

    // 1 = write for transaction index k
    function automatic logic mode_for(
        input logic [1:0] sel,
        input int unsigned k
    );
        logic w;
        w = 1'b1;
        unique case (sel)
            MODE_ALT_W: w = ~k[0];
            MODE_ALL_W: w = 1'b1;
            MODE_ALL_R: w = 1'b0;
            MODE_ALT_R: w = k[0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/demo_txn_sequencer_if.sv
// Bundle of the N_CH demo ports driven by the sequencer.
// master = sequencer side, slave = demo bus masters.
interface demo_txn_sequencer_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] demo_start;
    logic [N_CH-1:0] demo_mode;
    logic [N_CH-1:0] demo_ready;

    modport master (
        output demo_start,
        output demo_mode,
        input  demo_ready
    );

    modport slave (
        input  demo_start,
        input  demo_mode,
        output demo_ready
    );
endinterface

// File: rtl/demo_txn_sequencer_rr_next_sel.sv
// Round-robin pick: next set bit of i_mask above i_cur, wrapping.
// Returns i_cur itself when it is the only set bit.
module rr_next_sel #(
    parameter int N_CH = 2,
    parameter int CH_W = 1
) (
    input  logic [N_CH-1:0] i_mask,
    input  logic [CH_W-1:0] i_cur,
    output logic [CH_W-1:0] o_next
);
    logic [CH_W-1:0] w_idx;

    // descending scan: the smallest offset is written last and wins
    always_comb begin
        o_next = i_cur;
        w_idx  = i_cur;
        for (int i = N_CH; i >= 1; i--) begin
            w_idx = CH_W'((int'(i_cur) + i) % N_CH);
            if (i_mask[w_idx]) o_next = w_idx;
        end
    end
endmodule

// File: rtl/demo_txn_sequencer.sv
// Issues programmed write/read transactions round-robin over
// enabled demo ports, with completion timeout and status.
module demo_txn_sequencer
    import demo_seq_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 1,
    parameter int MIN_GAP   = 4,
    parameter int TO_W      = 12,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_txn,
    input  logic [1:0]       i_mode_sel,
    input  logic [N_CH-1:0]  i_ch_en,
    demo_txn_sequencer_if.master bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_txn_done_cnt,
    output logic [CH_W-1:0]  o_err_ch
);
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

    state_e           r_state;
    logic             r_run_q;
    logic [CNT_W-1:0] r_num;
    logic [1:0]       r_sel;
    logic [N_CH-1:0]  r_en;
    logic [CH_W-1:0]  r_ch;
    logic [CNT_W-1:0] r_k;
    logic [TO_W-1:0]  r_to;
    logic [N_CH-1:0]  r_start;
    logic [N_CH-1:0]  r_mode;
    logic             r_busy;
    logic             r_done;
    logic             r_to_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CH_W-1:0]  r_err_ch;

    logic             w_run_edge;
    logic [N_CH-1:0]  w_mask;
    logic [CH_W-1:0]  w_cur;
    logic [CH_W-1:0]  w_next;
    logic [CNT_W-1:0] w_k1;

    assign w_run_edge = i_run & ~r_run_q;
    assign w_k1       = r_k + CNT_W'(1);

    // in IDLE, searching above the top index yields the lowest set bit
    assign w_mask = (r_state == IDLE) ? i_ch_en : r_en;
    assign w_cur  = (r_state == IDLE) ? CH_W'(N_CH - 1) : r_ch;

    rr_next_sel #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr (
        .i_mask (w_mask),
        .i_cur  (w_cur),
        .o_next (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_run_q  <= 1'b0;
            r_num    <= '0;
            r_sel    <= '0;
            r_en     <= '0;
            r_ch     <= '0;
            r_k      <= '0;
            r_to     <= '0;
            r_start  <= '1;
            r_mode   <= '1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_to_err <= 1'b0;
            r_cnt    <= '0;
            r_err_ch <= '0;
        end else begin
            r_run_q <= i_run;
            if (i_abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_start <= '1;
            end else begin
                unique case (r_state)
                    IDLE: if (w_run_edge) begin
                        r_num    <= i_num_txn;
                        r_sel    <= i_mode_sel;
                        r_en     <= i_ch_en;
                        r_ch     <= w_next;
                        r_k      <= '0;
                        r_to     <= '0;
                        r_done   <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_to_err <= ~|i_ch_en;
                        if (i_num_txn == '0 || i_ch_en == '0)
                            r_state <= DONE;
                        else
                            r_state <= SETUP;
                    end
                    SETUP: begin
                        r_mode[r_ch] <= mode_for(r_sel, 32'(r_k));
                        if (r_to == TO_W'(SETUP_CYC - 1)) begin
                            r_to          <= '0;
                            r_start[r_ch] <= 1'b0;
                            r_state       <= PULSE;
                        end else begin
                            r_to <= r_to + TO_W'(1);
                        end
                    end
                    PULSE: begin
                        if (r_to == TO_W'(PULSE_CYC - 1)) begin
                            r_to    <= '0;
                            r_start <= '1;
                            r_state <= WAIT;
                        end else begin
                            r_to <= r_to + TO_W'(1);
                        end
                    end
                    WAIT: begin
                        if (r_to >= TO_W'(MIN_GAP) &&
                            bus.demo_ready[r_ch]) begin
                            if (r_cnt != '1)
                                r_cnt <= r_cnt + CNT_W'(1);
                            r_state <= NEXT;
                        end else if (r_to == TO_LAST) begin
                            r_to_err <= 1'b1;
                            r_err_ch <= r_ch;
                            r_state  <= DONE;
                        end else begin
                            r_to <= r_to + TO_W'(1);
                        end
                    end
                    NEXT: begin
                        r_k  <= w_k1;
                        r_to <= '0;
                        if (w_k1 == r_num) begin
                            r_state <= DONE;
                        end else begin
                            r_ch    <= w_next;
                            r_state <= SETUP;
                        end
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.demo_start  = r_start | {N_CH{i_abort}};
    assign bus.demo_mode   = r_mode;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_timeout_err   = r_to_err;
    assign o_txn_done_cnt  = r_cnt;
    assign o_err_ch        = r_err_ch;
endmodule

// File: tb/tb_demo_txn_sequencer.sv
// Directed bench for demo_txn_sequencer: vector table of whole
// sequences plus hand-written abort and reset sequences.
module tb_demo_txn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_txn = '0;
    logic [1:0] mode_sel = '0;
    logic [1:0] ch_en = '0;
    logic       busy, done, to_err;
    logic [7:0] cnt;
    logic       err_ch;

    demo_txn_sequencer_if #(.N_CH(2)) dif();

    demo_txn_sequencer #(
        .N_CH      (2),
        .CNT_W     (8),
        .SETUP_CYC (2),
        .PULSE_CYC (1),
        .MIN_GAP   (4),
        .TO_W      (12)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_run          (run),
        .i_abort        (abort),
        .i_num_txn      (num_txn),
        .i_mode_sel     (mode_sel),
        .i_ch_en        (ch_en),
        .bus            (dif),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout_err  (to_err),
        .o_txn_done_cnt (cnt),
        .o_err_ch       (err_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [1:0] sel;
        logic [1:0] en;
        logic [1:0] rdy;
        int         np;
        logic [7:0] ch;
        logic [7:0] md;
        logic [7:0] cnt;
        logic       to;
        logic       chk_err;
        logic       ech;
    } vec_t;

    vec_t tv[8];

    int n_chk = 0;
    int n_fail = 0;
    int np;
    int low_cyc;
    int ncyc;
    int to_at;
    int pcyc[8];
    logic [7:0] pch;
    logic [7:0] pmd;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic prev_low, multi, saw_busy, fin, c;
        num_txn  = v.n;
        mode_sel = v.sel;
        ch_en    = v.en;
        dif.demo_ready = v.rdy;
        np = 0; low_cyc = 0; to_at = -1; ncyc = 0;
        pch = '0; pmd = '0;
        prev_low = 1'b0; multi = 1'b0;
        saw_busy = 1'b0; fin = 1'b0;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        for (int cyc = 1; cyc <= 6000; cyc++) begin
            @(negedge clk);
            ncyc = cyc;
            if (busy) saw_busy = 1'b1;
            if (to_err && to_at < 0) to_at = cyc;
            if (dif.demo_start != 2'b11) begin
                low_cyc++;
                if (dif.demo_start == 2'b00) multi = 1'b1;
                if (!prev_low) begin
                    if (np < 8) begin
                        c = dif.demo_start[0];
                        pch[np]  = c;
                        pmd[np]  = dif.demo_mode[c];
                        pcyc[np] = cyc;
                    end
                    np++;
                end
            end
            prev_low = (dif.demo_start != 2'b11);
            if (done && !busy) begin
                fin = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_finish", idx), fin, 1);
        check($sformatf("v%0d_busy_seen", idx), saw_busy, 1);
        check($sformatf("v%0d_cnt", idx), cnt, v.cnt);
        check($sformatf("v%0d_to_err", idx), to_err, v.to);
        if (v.chk_err)
            check($sformatf("v%0d_err_ch", idx), err_ch, v.ech);
        check($sformatf("v%0d_npulse", idx), np, v.np);
        check($sformatf("v%0d_lowcyc", idx), low_cyc, v.np);
        check($sformatf("v%0d_onehot", idx), multi, 0);
        for (int i = 0; i < v.np && i < 8; i++) begin
            check($sformatf("v%0d_p%0d_ch", idx, i), pch[i], v.ch[i]);
            check($sformatf("v%0d_p%0d_mode", idx, i), pmd[i], v.md[i]);
        end
        if (v.np >= 2 && np >= 2)
            check($sformatf("v%0d_spacing", idx), pcyc[1] - pcyc[0], 9);
    endtask

    task automatic wait_start(input logic [1:0] pat, input string nm);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (dif.demo_start == pat) begin
                hit = 1'b1;
                break;
            end
        end
        check(nm, hit, 1);
    endtask

    initial begin
        logic seen;
        dif.demo_ready = 2'b11;
        //        n      sel   en     rdy    np ch        md        cnt   to  ce  ech
        tv[0] = '{8'd4, 2'd0, 2'b11, 2'b11, 4, 8'b1010, 8'b0101, 8'd4, 0, 0, 0};
        tv[1] = '{8'd3, 2'd2, 2'b10, 2'b11, 3, 8'b0111, 8'b0000, 8'd3, 0, 0, 0};
        tv[2] = '{8'd3, 2'd1, 2'b01, 2'b11, 3, 8'b0000, 8'b0111, 8'd3, 0, 0, 0};
        tv[3] = '{8'd3, 2'd3, 2'b11, 2'b11, 3, 8'b0010, 8'b0010, 8'd3, 0, 0, 0};
        tv[4] = '{8'd0, 2'd0, 2'b11, 2'b11, 0, 8'b0000, 8'b0000, 8'd0, 0, 0, 0};
        tv[5] = '{8'd2, 2'd0, 2'b00, 2'b11, 0, 8'b0000, 8'b0000, 8'd0, 1, 0, 0};
        tv[6] = '{8'd2, 2'd0, 2'b11, 2'b01, 2, 8'b0010, 8'b0001, 8'd1, 1, 1, 1};
        tv[7] = '{8'd2, 2'd0, 2'b11, 2'b11, 2, 8'b0010, 8'b0001, 8'd2, 0, 0, 0};

        #12;
        check("rst_start", dif.demo_start, 2'b11);
        check("rst_mode", dif.demo_mode, 2'b11);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_to_err", to_err, 0);
        check("rst_cnt", cnt, 0);
        check("rst_err_ch", err_ch, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(tv[i], i);
            if (i == 4) check("v4_latency", ncyc <= 3, 1);
        end
        check("to_wait_len", to_at - pcyc[1], 4096);

        // abort during the second pulse
        num_txn = 8'd4; mode_sel = 2'd0; ch_en = 2'b11;
        dif.demo_ready = 2'b11;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        wait_start(2'b01, "abort_reach_pulse2");
        #2 abort = 1'b1;
        #1 check("abort_mask", dif.demo_start, 2'b11);
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt", cnt, 1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (dif.demo_start != 2'b11 || busy) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);

        // abort and run edge together: run dropped
        @(posedge clk); #1 run = 1'b1; abort = 1'b1;
        @(posedge clk); #1 run = 1'b0; abort = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (dif.demo_start != 2'b11 || busy) seen = 1'b1;
        end
        check("abort_run_drop", seen, 0);

        // async reset while waiting on ch1
        num_txn = 8'd4; mode_sel = 2'd2; ch_en = 2'b11;
        dif.demo_ready = 2'b01;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        wait_start(2'b01, "rstw_reach_ch1");
        repeat (10) @(posedge clk);
        check("rstw_pre_cnt", cnt, 1);
        check("rstw_pre_mode", dif.demo_mode, 2'b00);
        #3 rst_n = 1'b0;
        #1;
        check("rstw_start", dif.demo_start, 2'b11);
        check("rstw_mode", dif.demo_mode, 2'b11);
        check("rstw_busy", busy, 0);
        check("rstw_cnt", cnt, 0);
        check("rstw_done", done, 0);
        check("rstw_to_err", to_err, 0);
        @(negedge clk) rst_n = 1'b1;
        run_vec(tv[7], 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
